// File: rtl/column_fill_tracker.sv
// Board-occupancy store: one thermometer fill register and one owner register
// per column, a drop-request FSM with valid/ready response, and a registered cell read port.
module column_fill_tracker #(
    parameter int COLS = 7,
    parameter int ROWS = 6,
    parameter int CW   = $clog2(COLS),
    parameter int HW   = $clog2(ROWS + 1)
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            clear,
    input  logic            drop_valid,
    input  logic [CW-1:0]   drop_col,
    input  logic            drop_player,
    output logic            drop_ready,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic            resp_ok,
    output logic [1:0]      resp_err,
    output logic [CW-1:0]   resp_col,
    output logic [HW-1:0]   resp_row,
    output logic [COLS-1:0] col_full,
    output logic            board_full,
    output logic [7:0]      move_count,
    input  logic [CW-1:0]   rd_col,
    input  logic [HW-1:0]   rd_row,
    output logic            rd_occ,
    output logic            rd_player
);

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_WRITE, S_RESP} state_t;

    state_t                      r_state;
    logic [COLS-1:0][ROWS-1:0]   r_fill;
    logic [COLS-1:0][ROWS-1:0]   r_own;
    logic [CW-1:0]               r_col;
    logic                        r_player;
    logic                        r_drop_ready;
    logic                        r_resp_valid;
    logic                        r_resp_ok;
    logic [1:0]                  r_resp_err;
    logic [CW-1:0]               r_resp_col;
    logic [HW-1:0]               r_resp_row;
    logic [7:0]                  r_move_count;
    logic                        r_rd_occ;
    logic                        r_rd_player;

    logic                        w_col_hit;
    logic [ROWS-1:0]             w_sel_fill;
    logic                        w_rd_occ;
    logic                        w_rd_own;

    // Fill is a thermometer code, so the height is simply its population count.
    function automatic logic [HW-1:0] f_height(input logic [ROWS-1:0] f);
        logic [HW-1:0] n;
        n = '0;
        for (int i = 0; i < ROWS; i++)
            n = n + HW'(f[i]);
        return n;
    endfunction

    // Column select by compare keeps out-of-range indices from ever addressing storage.
    always_comb begin
        w_col_hit  = 1'b0;
        w_sel_fill = '0;
        for (int c = 0; c < COLS; c++) begin
            if (r_col == CW'(c)) begin
                w_col_hit  = 1'b1;
                w_sel_fill = r_fill[c];
            end
        end
    end

    always_comb begin
        w_rd_occ = 1'b0;
        w_rd_own = 1'b0;
        for (int c = 0; c < COLS; c++) begin
            for (int r = 0; r < ROWS; r++) begin
                if (rd_col == CW'(c) && rd_row == HW'(r)) begin
                    w_rd_occ = r_fill[c][r];
                    w_rd_own = r_own[c][r];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= S_IDLE;
            r_fill       <= '0;
            r_own        <= '0;
            r_col        <= '0;
            r_player     <= 1'b0;
            r_drop_ready <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_ok    <= 1'b0;
            r_resp_err   <= 2'b00;
            r_resp_col   <= '0;
            r_resp_row   <= '0;
            r_move_count <= 8'd0;
        end else if (clear) begin
            r_state      <= S_IDLE;
            r_fill       <= '0;
            r_own        <= '0;
            r_drop_ready <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_ok    <= 1'b0;
            r_resp_err   <= 2'b00;
            r_resp_col   <= '0;
            r_resp_row   <= '0;
            r_move_count <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (drop_valid) begin
                        r_col        <= drop_col;
                        r_player     <= drop_player;
                        r_drop_ready <= 1'b0;
                        r_state      <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    r_resp_col <= r_col;
                    if (!w_col_hit) begin
                        r_resp_ok    <= 1'b0;
                        r_resp_err   <= 2'b10;
                        r_resp_row   <= '0;
                        r_resp_valid <= 1'b1;
                        r_state      <= S_RESP;
                    end else if (&w_sel_fill) begin
                        r_resp_ok    <= 1'b0;
                        r_resp_err   <= 2'b01;
                        r_resp_row   <= '0;
                        r_resp_valid <= 1'b1;
                        r_state      <= S_RESP;
                    end else begin
                        r_resp_ok  <= 1'b1;
                        r_resp_err <= 2'b00;
                        r_resp_row <= f_height(w_sel_fill);
                        r_state    <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    for (int c = 0; c < COLS; c++) begin
                        if (r_col == CW'(c)) begin
                            r_fill[c] <= {r_fill[c][ROWS-2:0], 1'b1};
                            for (int r = 0; r < ROWS; r++)
                                if (r_resp_row == HW'(r))
                                    r_own[c][r] <= r_player;
                        end
                    end
                    if (r_move_count != 8'hFF)
                        r_move_count <= r_move_count + 8'd1;
                    r_resp_valid <= 1'b1;
                    r_state      <= S_RESP;
                end
                S_RESP: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_drop_ready <= 1'b1;
                        r_state      <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rd_occ    <= 1'b0;
            r_rd_player <= 1'b0;
        end else if (clear) begin
            r_rd_occ    <= 1'b0;
            r_rd_player <= 1'b0;
        end else begin
            r_rd_occ    <= w_rd_occ;
            r_rd_player <= w_rd_own & w_rd_occ;
        end
    end

    always_comb begin
        for (int c = 0; c < COLS; c++)
            col_full[c] = &r_fill[c];
    end

    assign board_full = &col_full;
    assign drop_ready = r_drop_ready;
    assign resp_valid = r_resp_valid;
    assign resp_ok    = r_resp_ok;
    assign resp_err   = r_resp_err;
    assign resp_col   = r_resp_col;
    assign resp_row   = r_resp_row;
    assign move_count = r_move_count;
    assign rd_occ     = r_rd_occ;
    assign rd_player  = r_rd_player;

endmodule
